// File: rtl/calc_sequencer.sv
// Front-end sequencer for the calculator ALU: turns button pulses into operand-latch
// strobes and an op code, traps divide-by-zero and times out abandoned operand entry.
module calc_sequencer #(
  parameter int unsigned ARIF     = 4,
  parameter int unsigned RECORD   = 2,
  parameter int unsigned CONTROL  = 3,
  parameter int unsigned EXEC_CYC = 2,
  parameter int unsigned TIMEOUT  = 0,
  parameter int unsigned TO_W     = 24
) (
  input  logic               clk_SEQ,
  input  logic               rst_SEQ,
  input  logic               btn_load,
  input  logic [ARIF-1:0]    btn_op,
  input  logic               btn_clr,
  input  logic [CONTROL-1:0] control_from_alu,
  output logic [RECORD-1:0]  keys_to_alu,
  output logic [ARIF-1:0]    arif_to_alu,
  output logic [2:0]         state_out,
  output logic               busy,
  output logic               err
);

  localparam int unsigned EW = (EXEC_CYC > 1) ? $clog2(EXEC_CYC) : 1;

  localparam logic [ARIF-1:0]   ArifNone = '1;
  localparam logic [ARIF-1:0]   OpDiv    = {1'b0, {(ARIF-1){1'b1}}};
  localparam logic [RECORD-1:0] KeyA     = RECORD'(2);
  localparam logic [RECORD-1:0] KeyB     = RECORD'(1);

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StA    = 3'd1,
    StB    = 3'd2,
    StExec = 3'd4,
    StShow = 3'd5,
    StErr  = 3'd6
  } state_e;

  state_e            state_q, state_d;
  logic [EW-1:0]     exec_q, exec_d;
  logic [TO_W-1:0]   to_q, to_d, to_inc;
  logic [RECORD-1:0] keys_q, keys_d;
  logic [ARIF-1:0]   arif_q, arif_d;
  logic              busy_q, err_q;
  logic              op_valid, ld, timeout_hit;

  assign op_valid    = ($countones(~btn_op) == 1);
  // A load arriving on a strobe cycle is dropped so keys never stay nonzero two cycles.
  assign ld          = btn_load && (keys_q == '0);
  assign timeout_hit = (TIMEOUT != 0) && (to_q == TO_W'(TIMEOUT - 1));
  assign to_inc      = (to_q == '1) ? to_q : to_q + 1'b1;

  always_ff @(posedge clk_SEQ) begin
    if (rst_SEQ) begin
      state_q <= StIdle;
      exec_q  <= '0;
      to_q    <= '0;
      keys_q  <= '0;
      arif_q  <= ArifNone;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      exec_q  <= exec_d;
      to_q    <= to_d;
      keys_q  <= keys_d;
      arif_q  <= arif_d;
      busy_q  <= (state_d == StExec);
      err_q   <= (state_d == StErr);
    end
  end

  always_comb begin
    state_d = state_q;
    exec_d  = exec_q;
    to_d    = to_q;
    if (btn_clr) begin
      state_d = StIdle;
      exec_d  = '0;
      to_d    = '0;
    end else begin
      case (state_q)
        StIdle: if (ld) begin
          state_d = StA;
          to_d    = '0;
        end
        StA: begin
          if (ld) begin
            state_d = StB;
            to_d    = '0;
          end else if (timeout_hit) state_d = StIdle;
          else to_d = to_inc;
        end
        StB: begin
          if (op_valid) begin
            state_d = StExec;
            exec_d  = EW'(EXEC_CYC - 1);
          end else if (ld) to_d = '0;
          else if (timeout_hit) state_d = StIdle;
          else to_d = to_inc;
        end
        StExec: begin
          if (exec_q == '0) begin
            state_d = (arif_q == OpDiv && control_from_alu == CONTROL'(2)) ? StErr : StShow;
          end else exec_d = exec_q - 1'b1;
        end
        StShow: begin
          if (op_valid) begin
            state_d = StExec;
            exec_d  = EW'(EXEC_CYC - 1);
          end else if (ld) begin
            state_d = StA;
            to_d    = '0;
          end
        end
        StErr:   ;
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    keys_d = '0;
    arif_d = arif_q;
    if (btn_clr) begin
      arif_d = ArifNone;
    end else begin
      case (state_q)
        StIdle: begin
          arif_d = ArifNone;
          if (ld) keys_d = KeyA;
        end
        StA: begin
          arif_d = ArifNone;
          if (ld) keys_d = KeyB;
        end
        StB: begin
          if (op_valid) arif_d = btn_op;
          else if (ld) keys_d = KeyB;
          else if (timeout_hit) arif_d = ArifNone;
        end
        StExec: ;
        StShow: begin
          if (op_valid) arif_d = btn_op;
          else if (ld) begin
            keys_d = KeyA;
            arif_d = ArifNone;
          end
        end
        StErr:   arif_d = OpDiv;
        default: arif_d = ArifNone;
      endcase
    end
  end

  assign keys_to_alu = keys_q;
  assign arif_to_alu = arif_q;
  assign state_out   = state_q;
  assign busy        = busy_q;
  assign err         = err_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Scoreboarded bench for calc_sequencer: directed scenarios then randomized button traffic,
// checked cycle by cycle against a behavioural model of the sequencing rules.
module tb_calc_sequencer;

  localparam int EXEC_CYC = 2;
  localparam int TIMEOUT  = 8;

  logic       clk_SEQ = 1'b0;
  logic       rst_SEQ, btn_load, btn_clr;
  logic [3:0] btn_op;
  logic [2:0] control_from_alu;
  logic [1:0] keys_to_alu;
  logic [3:0] arif_to_alu;
  logic [2:0] state_out;
  logic       busy, err;

  always #5 clk_SEQ = ~clk_SEQ;

  calc_sequencer #(
    .ARIF(4), .RECORD(2), .CONTROL(3), .EXEC_CYC(EXEC_CYC), .TIMEOUT(TIMEOUT), .TO_W(24)
  ) dut (
    .clk_SEQ(clk_SEQ), .rst_SEQ(rst_SEQ), .btn_load(btn_load), .btn_op(btn_op),
    .btn_clr(btn_clr), .control_from_alu(control_from_alu), .keys_to_alu(keys_to_alu),
    .arif_to_alu(arif_to_alu), .state_out(state_out), .busy(busy), .err(err)
  );

  typedef struct packed {
    logic [2:0] st;
    logic [1:0] keys;
    logic [3:0] arif;
    logic       busy;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_cyc = 0;
  bit   prev_load = 1'b0;

  // Model state: state number, outputs, remaining exec cycles, idle cycles in entry states.
  int         ms = 0;
  logic [1:0] mkeys = 2'b00;
  logic [3:0] marif = 4'hF;
  logic [3:0] mop = 4'hF;
  int         mexec_left = 0;
  int         midle = 0;

  function automatic bit single_zero(input logic [3:0] op);
    int z = 0;
    for (int i = 0; i < 4; i++) if (!op[i]) z++;
    return z == 1;
  endfunction

  task automatic model(input bit rst, input bit clr, input bit ld, input logic [3:0] op,
                       input logic [2:0] ctrl);
    bit valid = single_zero(op);
    mkeys = 2'b00;
    if (rst || clr) begin
      ms = 0; marif = 4'hF; midle = 0; mexec_left = 0;
    end else begin
      case (ms)
        0: begin
          marif = 4'hF;
          if (ld) begin ms = 1; mkeys = 2'b10; midle = 0; end
        end
        1: begin
          marif = 4'hF;
          if (ld) begin ms = 2; mkeys = 2'b01; midle = 0; end
          else if (midle + 1 >= TIMEOUT) ms = 0;
          else midle++;
        end
        2: begin
          if (valid) begin ms = 4; marif = op; mop = op; mexec_left = EXEC_CYC; end
          else if (ld) begin mkeys = 2'b01; midle = 0; end
          else if (midle + 1 >= TIMEOUT) begin ms = 0; marif = 4'hF; end
          else midle++;
        end
        4: begin
          mexec_left--;
          if (mexec_left == 0) ms = (mop == 4'b0111 && ctrl == 3'd2) ? 6 : 5;
        end
        5: begin
          if (valid) begin ms = 4; marif = op; mop = op; mexec_left = EXEC_CYC; end
          else if (ld) begin ms = 1; mkeys = 2'b10; marif = 4'hF; midle = 0; end
        end
        6: marif = 4'b0111;
        default: ms = 0;
      endcase
    end
  endtask

  task automatic step(input bit rst, input bit clr, input bit ld, input logic [3:0] op,
                      input logic [2:0] ctrl);
    exp_t e;
    @(negedge clk_SEQ);
    if (prev_load) ld = 1'b0;  // button edge logic never produces back-to-back pulses
    prev_load = ld;
    rst_SEQ = rst; btn_clr = clr; btn_load = ld; btn_op = op; control_from_alu = ctrl;
    model(rst, clr, ld, op, ctrl);
    e.st = 3'(ms); e.keys = mkeys; e.arif = marif; e.busy = (ms == 4); e.err = (ms == 6);
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 4'hF, 3'd0);
  endtask

  task automatic load();
    step(0, 0, 1, 4'hF, 3'd0);
  endtask

  task automatic op(input logic [3:0] o, input logic [2:0] ctrl);
    step(0, 0, 0, o, ctrl);
  endtask

  initial begin : monitor
    exp_t e, g;
    forever begin
      @(posedge clk_SEQ);
      #1;
      n_cyc++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        g = {state_out, keys_to_alu, arif_to_alu, busy, err};
        n_cmp++;
        if (g !== e) begin
          n_bad++;
          $display("FAIL outputs cycle %0d: got st=%0d keys=%b arif=%b busy=%b err=%b, expected st=%0d keys=%b arif=%b busy=%b err=%b",
                   n_cyc, g.st, g.keys, g.arif, g.busy, g.err, e.st, e.keys, e.arif, e.busy,
                   e.err);
        end
      end
    end
  end

  initial begin : stimulus
    int lp, r;
    bit ld, clr, rst;
    logic [3:0] o;
    logic [2:0] c;
    rst_SEQ = 1'b1; btn_load = 1'b0; btn_clr = 1'b0; btn_op = 4'hF; control_from_alu = '0;
    step(1, 0, 0, 4'hF, 3'd0);
    step(1, 0, 0, 4'hF, 3'd0);
    idle(2);
    // add: A, B, op 1110, show
    load(); idle(1); load(); op(4'b1110, 3'd0); idle(4);
    // sub then re-execute multiply on the same operands
    load(); idle(1); load(); op(4'b1101, 3'd1); idle(3); op(4'b1011, 3'd0); idle(3);
    // divide by zero traps; buttons ignored until clear
    load(); idle(1); load(); op(4'b0111, 3'd2); op(4'hF, 3'd2); op(4'hF, 3'd2); idle(2);
    op(4'b1110, 3'd0); load(); idle(1); step(0, 1, 0, 4'hF, 3'd0); idle(2);
    // op beats simultaneous load in S_B; two-zero op ignored
    load(); idle(1); load(); idle(1); op(4'b1100, 3'd0); step(0, 0, 1, 4'b1110, 3'd0); idle(4);
    // timeout from S_A, and a load late in the window restarting it
    load(); idle(10); load(); idle(6); load(); idle(10);
    // reset mid-exec, clear in S_A
    load(); idle(1); load(); op(4'b1110, 3'd0); step(1, 0, 0, 4'hF, 3'd0); idle(2);
    load(); step(0, 1, 0, 4'hF, 3'd0); idle(2);

    for (int blk = 0; blk < 15; blk++) begin
      lp = $urandom_range(5, 45);
      for (int i = 0; i < 200; i++) begin
        ld  = ($urandom_range(0, 99) < lp);
        clr = ($urandom_range(0, 99) < 3);
        rst = ($urandom_range(0, 199) < 1);
        r   = $urandom_range(0, 99);
        if (r < 50) o = 4'hF;
        else if (r < 85) o = ~(4'b0001 << $urandom_range(0, 3));
        else o = 4'($urandom_range(0, 15));
        c = ($urandom_range(0, 99) < 40) ? 3'd2 : 3'($urandom_range(0, 7));
        step(rst, clr, ld, o, c);
      end
    end

    repeat (3) @(posedge clk_SEQ);
    #2;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
